// File: rtl/mvm_stream_master.sv
// Host-side master for the 3x3 matrix-vector MAC: streams a 12-byte frame, collects 3 results.
// Optional receive watchdog enabled by defining MVM_STREAM_MASTER_TIMEOUT_EN.
module mvm_stream_master #(
  parameter int DATA_W         = 8,
  parameter int RES_W          = 16,
  parameter int N_MAT          = 9,
  parameter int N_VEC          = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              start,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [RES_W-1:0]  rx_data,
  input  logic [1:0]        res_addr,
  output logic [RES_W-1:0]  res_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int N_TOT = N_MAT + N_VEC;
  localparam logic [3:0] TX_LAST = 4'(N_TOT - 1);
  localparam logic [3:0] TX_END  = 4'(N_TOT);
  localparam logic [1:0] RX_LAST = 2'(N_VEC - 1);
  localparam logic [1:0] RX_END  = 2'(N_VEC);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t            state;
  logic [3:0]        tx_idx;
  logic [1:0]        rx_idx;
  logic [DATA_W-1:0] frame_buf [N_TOT];
  logic [RES_W-1:0]  res [N_VEC];

`ifdef MVM_STREAM_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] to_cnt;
  logic          err_q;
  assign err = err_q;
`else
  // Without the watchdog the flag can never be raised; the parameter only feeds this constant.
  assign err = (TIMEOUT_CYCLES < 0);
`endif

  // The buffer is host-owned storage and deliberately survives reset.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE && cfg_addr < TX_END)
      frame_buf[cfg_addr] <= cfg_wdata;
  end

  assign tx_data   = (tx_idx < TX_END) ? frame_buf[tx_idx] : '0;
  assign res_rdata = (res_addr < RX_END) ? res[res_addr] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      rx_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_idx   <= '0;
      rx_idx   <= '0;
      for (int i = 0; i < N_VEC; i++) res[i] <= '0;
`ifdef MVM_STREAM_MASTER_TIMEOUT_EN
      to_cnt   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= SEND;
          tx_valid <= 1'b1;
          busy     <= 1'b1;
          tx_idx   <= '0;
          rx_idx   <= '0;
`ifdef MVM_STREAM_MASTER_TIMEOUT_EN
          err_q    <= 1'b0;
`endif
        end
        SEND: if (tx_valid && tx_ready) begin
          tx_idx <= tx_idx + 4'd1;
          if (tx_idx == TX_LAST) begin
            state    <= RECV;
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
`ifdef MVM_STREAM_MASTER_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end
        RECV: begin
          if (rx_valid && rx_ready) begin
            res[rx_idx] <= rx_data;
            rx_idx      <= rx_idx + 2'd1;
`ifdef MVM_STREAM_MASTER_TIMEOUT_EN
            to_cnt      <= '0;
`endif
            if (rx_idx == RX_LAST) begin
              state    <= DONE;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
`ifdef MVM_STREAM_MASTER_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state    <= DONE;
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            err_q    <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_stream_master.sv
// Directed bench for mvm_stream_master: frame streaming, backpressure, ignored inputs, reset abort.
module tb_mvm_stream_master;

`ifdef MVM_STREAM_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [7:0]  cfg_wdata = '0;
  logic        start = 1'b0;
  logic        tx_valid, tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        rx_valid = 1'b0, rx_ready;
  logic [15:0] rx_data = '0;
  logic [1:0]  res_addr = '0;
  logic [15:0] res_rdata;
  logic        busy, done, err;

  mvm_stream_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .res_addr(res_addr), .res_rdata(res_rdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_buf [12];
  logic [7:0] sent [12];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [15:0] r0, input logic [15:0] r1,
                           input logic [15:0] r2);
    res_addr = 2'd0; #1 check({tag, "_r0"}, res_rdata, r0);
    res_addr = 2'd1; #1 check({tag, "_r1"}, res_rdata, r1);
    res_addr = 2'd2; #1 check({tag, "_r2"}, res_rdata, r2);
    res_addr = 2'd3; #1 check({tag, "_r3"}, res_rdata, 0);
  endtask

  // Called at a negedge in IDLE. Caller may preset cfg_we to exercise write+start together.
  task automatic send(input string tag, input bit toggle, input bit disturb, input bit noise,
                      input int exp_cyc);
    int hs = 0, ncyc = 0;
    bit pend = 1'b0;
    logic [7:0] prev = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    check({tag, "_lat"}, {tx_valid, busy}, 2'b11);
    while (hs < 12 && ncyc < 100) begin
      tx_ready = toggle ? (ncyc % 2 == 0) : 1'b1;
      rx_valid = noise; rx_data = 16'hAAAA;
      cfg_we = disturb && ncyc == 2; cfg_addr = 4'd3; cfg_wdata = 8'hFF;
      start  = disturb && (ncyc == 2 || ncyc == 5);
      if (pend) check({tag, "_hold"}, tx_data, prev);
      if (rx_ready) check({tag, "_rxrdy"}, rx_ready, 0);
      if (tx_valid && tx_ready) begin
        sent[hs] = tx_data; hs++; pend = 1'b0;
      end else begin
        pend = tx_valid; prev = tx_data;
      end
      ncyc++;
      @(negedge clk);
    end
    tx_ready = 1'b0; rx_valid = 1'b0; cfg_we = 1'b0; start = 1'b0;
    check({tag, "_hs"}, hs, 12);
    check({tag, "_cyc"}, ncyc, exp_cyc);
    for (int i = 0; i < 12; i++) check($sformatf("%s_b%0d", tag, i), sent[i], exp_buf[i]);
    check({tag, "_torecv"}, {tx_valid, rx_ready, busy}, 3'b011);
  endtask

  task automatic recv(input string tag, input int n, input logic [15:0] r0, input logic [15:0] r1,
                      input logic [15:0] r2, input bit poke_start);
    logic [15:0] v [3];
    v[0] = r0; v[1] = r1; v[2] = r2;
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1; rx_data = v[i]; tx_ready = 1'b1;
      start = poke_start && i == 0;
      @(negedge clk);
    end
    rx_valid = 1'b0; tx_ready = 1'b0; start = 1'b0;
    if (n == 3) begin
      check({tag, "_done"}, {done, busy, rx_ready, tx_valid}, 4'b1000);
      @(negedge clk);
      check({tag, "_after"}, {done, busy, tx_valid}, 3'b000);
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) exp_buf[i] = 8'(i + 1);
    exp_buf[9] = 8'd1; exp_buf[10] = 8'd2; exp_buf[11] = 8'd3;

    @(negedge clk);
    check("rst_ctl", {tx_valid, rx_ready, busy, done, err}, 5'b0);
    check_res("rst", 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) wr(4'(i), exp_buf[i]);
    wr(4'd12, 8'h77);

    // Frame 1: back-to-back ready, 12 bytes in 12 cycles.
    send("f1", 1'b0, 1'b0, 1'b0, 12);
    recv("f1", 3, 16'd14, 16'd32, 16'd50, 1'b0);
    check_res("f1", 16'd14, 16'd32, 16'd50);

    // Frame 2: ready toggling, with rx noise during SEND.
    send("f2", 1'b1, 1'b0, 1'b1, 23);
    check_res("f2_noise", 16'd14, 16'd32, 16'd50);
    recv("f2", 3, 16'd5, 16'd6, 16'd7, 1'b0);
    check_res("f2", 16'd5, 16'd6, 16'd7);

    // Frame 3: writes and starts while busy must be ignored.
    send("f3", 1'b0, 1'b1, 1'b0, 12);
    recv("f3", 3, 16'd14, 16'd32, 16'd50, 1'b1);
    check("f3_norestart", {busy, tx_valid}, 2'b00);
    send("f3b", 1'b0, 1'b0, 1'b0, 12);
    recv("f3b", 3, 16'd1, 16'd2, 16'd3, 1'b0);

    // Reset after the 5th handshake aborts the frame.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_mid", {tx_valid, busy}, 2'b11);
    reset = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    check("abort_ctl", {tx_valid, rx_ready, busy, done}, 4'b0);
    check_res("abort", 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);

    // Write and start in the same cycle; the new byte is sent.
    exp_buf[0] = 8'h21;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 8'h21;
    send("f4", 1'b0, 1'b0, 1'b0, 12);
    recv("f4", 3, 16'h1234, 16'h0, 16'hFFFF, 1'b0);
    check_res("f4", 16'h1234, 16'h0, 16'hFFFF);

`ifdef MVM_STREAM_MASTER_TIMEOUT_EN
    begin
      int k = 0;
      reset = 1'b0; @(negedge clk); reset = 1'b1; @(negedge clk);
      send("to", 1'b0, 1'b0, 1'b0, 12);
      recv("to", 1, 16'd99, 16'd0, 16'd0, 1'b0);
      while (!done && k < 100) begin @(negedge clk); k++; end
      check("to_delay", k, 16);
      check("to_err", {done, err, busy}, 3'b110);
      check_res("to", 16'd99, 0, 0);
      @(negedge clk);
      check("to_sticky", err, 1);
      start = 1'b1; @(negedge clk); start = 1'b0;
      check("to_clear", err, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mvm_stream_master.md
Name: mvm_stream_master

Overview:
- Host-side master for the 3x3 matrix-vector MAC stream unit.
- Holds a 12-byte frame buffer loaded by the host: 9 matrix bytes, row-major, then 3 vector bytes.
- On start, it transmits the frame over a valid/ready byte stream into the MAC slave port.
- It then collects the 3 16-bit results from the MAC master port and exposes them to the host through a read port, with a done pulse.

Parameters:
- DATA_W, 8, width of transmitted matrix/vector elements.
- RES_W, 16, width of received result words.
- N_MAT, 9, matrix elements per frame.
- N_VEC, 3, vector elements per frame; also the number of results.
- TIMEOUT_CYCLES, 1024, receive watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- cfg_we  in  1  frame buffer write strobe.
- cfg_addr  in  4  frame buffer index: 0-8 matrix, 9-11 vector.
- cfg_wdata  in  DATA_W  frame buffer write data.
- start  in  1  single-cycle start request.
- tx_valid  out  1  byte valid toward MAC s_valid.
- tx_ready  in  1  MAC s_ready.
- tx_data  out  DATA_W  byte toward MAC data_in.
- rx_valid  in  1  MAC m_valid.
- rx_ready  out  1  toward MAC m_ready.
- rx_data  in  RES_W  MAC data_out.
- res_addr  in  2  result read index 0-2.
- res_rdata  out  RES_W  result read data, combinational from res_addr.
- busy  out  1  high in SEND and RECV.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (reset=0 at posedge):
  - State goes to IDLE.
  - tx_valid=0, rx_ready=0, busy=0, done=0, err=0.
  - tx index and rx index cleared; result registers cleared to 0.
  - The frame buffer is not cleared.
  - Reset mid-frame aborts immediately. A partial transfer is not resumed.
- Frame buffer writes:
  - A write occurs on cfg_we=1 only when in IDLE.
  - Writes with cfg_addr 12-15 are ignored.
  - Writes during SEND, RECV or DONE are ignored.
- State machine:
  - IDLE: start=1 -> SEND. Clear tx index and rx index; clear err. Results keep their previous values until overwritten.
  - SEND:
    - tx_valid=1 and tx_data=buf[tx index].
    - tx_data is held stable until the handshake (tx_valid&tx_ready at a posedge).
    - Each handshake increments the tx index.
    - The handshake at index 11 -> RECV. tx_valid drops the next cycle.
    - There are no bubbles: back-to-back ready gives 12 bytes in 12 cycles.
  - RECV:
    - rx_ready=1.
    - Each rx_valid&rx_ready posedge stores rx_data into res[rx index] and increments the index.
    - The handshake at index 2 -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0, rx_ready=0, then -> IDLE.
- Latency: start to first tx_valid is 1 cycle. The last rx handshake to done is 1 cycle.
- start is ignored outside IDLE.
- start and cfg_we in the same IDLE cycle: the write is performed and the frame starts. The new byte is used.
- rx_valid in IDLE or SEND is ignored (rx_ready=0); no result is stored.
- tx_ready in IDLE, RECV or DONE is ignored (tx_valid=0).
- res_addr=3 returns 0.
- Results are readable at any time, including while busy. During RECV they show partially updated values.
- Indices never wrap mid-frame; each is cleared only on start or reset.

Optional Feature:
- Macro MVM_STREAM_MASTER_TIMEOUT_EN.
- When defined:
  - A counter runs in RECV. It is cleared on entry to RECV and on every rx handshake.
  - If it reaches TIMEOUT_CYCLES without a handshake: set err=1 (sticky until next start), go to DONE, and pulse done.
  - Results not yet received stay 0.
- When undefined: err is tied 0 and RECV waits indefinitely.

Test Plan:
- Load buf = 1..9 matrix, vector {1,2,3}, start, tx_ready=1, respond rx 14,32,50 -> tx_data sequence 1..9,1,2,3 in 12 consecutive cycles; res[0..2]=14,32,50; done one cycle after the 3rd rx handshake; busy low after.
- Same frame with tx_ready toggling 1/0 every cycle -> exactly 12 handshakes, tx_data stable while tx_ready=0, no duplicated or skipped byte.
- cfg_we to addr 3 with 0xFF during SEND, plus start pulses in SEND/RECV -> buffer unchanged; a second frame sends the original byte; no restart.
- Assert reset=0 after the 5th tx handshake -> next cycle tx_valid=0, busy=0, results 0. A subsequent start sends from index 0.
- rx_valid=1 with rx_data=0xAAAA during SEND -> not captured; res unchanged until RECV.
- With TIMEOUT_EN, TIMEOUT_CYCLES=16, only 1 result returned -> err=1, done pulse 16 cycles after that handshake, res[1]=res[2]=0. Next start clears err.
